// File: rtl/companion_rhs_builder.sv
// Builds the solver right-hand side z from the companion-model history currents.
// A single signed multiplier is shared over the IDLE -> MUL_L -> MUL_C -> UPD sequence.
module companion_rhs_builder #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clear,
    input  logic [DW-1:0] v1,
    input  logic [DW-1:0] v2,
    input  logic [DW-1:0] e_in,
    input  logic [DW-1:0] k_l,
    input  logic [DW-1:0] k_c,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] i_l,
    output logic [DW-1:0] i_c,
    output logic [DW-1:0] z0,
    output logic [DW-1:0] z1,
    output logic [DW-1:0] z2
);

    // Wide enough for a (DW+1)-bit difference times a DW-bit coefficient with headroom.
    localparam int WW = 2 * DW + 2;
    localparam logic signed [WW-1:0] MAX_W = WW'(signed'({1'b0, {(DW-1){1'b1}}}));
    localparam logic signed [WW-1:0] MIN_W = WW'(signed'({1'b1, {(DW-1){1'b0}}}));

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_L,
        S_MUL_C,
        S_UPD
    } state_t;

    function automatic logic signed [DW-1:0] sat(input logic signed [WW-1:0] x);
        if (x > MAX_W) begin
            return MAX_W[DW-1:0];
        end else if (x < MIN_W) begin
            return MIN_W[DW-1:0];
        end
        return x[DW-1:0];
    endfunction

    state_t state_q, state_d;
    logic done_q, done_d;
    logic signed [DW-1:0] v1_q, v1_d, v2_q, v2_d, e_q, e_d, kl_q, kl_d, kc_q, kc_d;
    logic signed [DW-1:0] pl_q, pl_d, pc_q, pc_d;
    logic signed [DW-1:0] il_q, il_d, ic_q, ic_d;
    logic signed [DW-1:0] z0_q, z0_d, z1_q, z1_d, z2_q, z2_d;

    logic signed [DW:0]    diff;
    logic signed [WW-1:0]  mul_a, mul_b;
    logic signed [DW-1:0]  mul_p;
    logic signed [DW-1:0]  ic_new;

    assign diff = (DW+1)'(v1_q) - (DW+1)'(v2_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        done_d  = 1'b0;
        v1_d    = v1_q;
        v2_d    = v2_q;
        e_d     = e_q;
        kl_d    = kl_q;
        kc_d    = kc_q;
        pl_d    = pl_q;
        pc_d    = pc_q;
        il_d    = il_q;
        ic_d    = ic_q;
        z0_d    = z0_q;
        z1_d    = z1_q;
        z2_d    = z2_q;

        // Multiplier operands follow the state: (v1-v2)*k_l first, then v2*k_c.
        if (state_q == S_MUL_L) begin
            mul_a = WW'(diff);
            mul_b = WW'(kl_q);
        end else begin
            mul_a = WW'(v2_q);
            mul_b = WW'(kc_q);
        end
        mul_p  = sat((mul_a * mul_b) >>> FRAC);
        ic_new = sat(-WW'(ic_q) + WW'(pc_q));

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    il_d = '0;
                    ic_d = '0;
                    z0_d = '0;
                    z1_d = '0;
                end else if (start) begin
                    v1_d    = v1;
                    v2_d    = v2;
                    e_d     = e_in;
                    kl_d    = k_l;
                    kc_d    = k_c;
                    state_d = S_MUL_L;
                end
            end
            S_MUL_L: begin
                pl_d    = mul_p;
                state_d = S_MUL_C;
            end
            S_MUL_C: begin
                il_d    = sat(WW'(il_q) + WW'(pl_q));
                pc_d    = mul_p;
                state_d = S_UPD;
            end
            S_UPD: begin
                ic_d    = ic_new;
                z0_d    = sat(-WW'(il_q));
                z1_d    = sat(WW'(il_q) + WW'(ic_new));
                z2_d    = e_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            v1_q    <= '0;
            v2_q    <= '0;
            e_q     <= '0;
            kl_q    <= '0;
            kc_q    <= '0;
            pl_q    <= '0;
            pc_q    <= '0;
            il_q    <= '0;
            ic_q    <= '0;
            z0_q    <= '0;
            z1_q    <= '0;
            z2_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            e_q     <= e_d;
            kl_q    <= kl_d;
            kc_q    <= kc_d;
            pl_q    <= pl_d;
            pc_q    <= pc_d;
            il_q    <= il_d;
            ic_q    <= ic_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign i_l  = il_q;
    assign i_c  = ic_q;
    assign z0   = z0_q;
    assign z1   = z1_q;
    assign z2   = z2_q;

endmodule
